// File: rtl/multi_ch_pulse_sync.sv
// multi_ch_pulse_sync: per-channel synchroniser, edge select, stretched pulse and saturating event queue
// Ports:
//   fast_clk   destination clock
//   rst_n      asynchronous active-low reset
//   async_in   slow-domain event inputs, one bit per channel
//   ch_en      channel enable (fast_clk domain)
//   edge_mode  per channel [2i+1:2i]: 00 rise, 01 fall, 10 both, 11 rise
//   ovf_clr    one-cycle clear of the sticky overflow flag
//   fast_pulse PULSE_W-cycle pulse per accepted event
//   busy       channel active or events still queued
//   overflow   sticky: an event was dropped on a full queue
module multi_ch_pulse_sync #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_W     = 1,
    parameter int CNT_W       = 2
) (
    input  logic                  fast_clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     async_in,
    input  logic [NUM_CH-1:0]     ch_en,
    input  logic [2*NUM_CH-1:0]   edge_mode,
    input  logic [NUM_CH-1:0]     ovf_clr,
    output logic [NUM_CH-1:0]     fast_pulse,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     overflow
);
    localparam int WC_W = $clog2(PULSE_W + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [WC_W-1:0] WC_INIT = WC_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   p_q;
        logic                   rise;
        logic                   fall;
        logic                   evt;
        logic                   drop;
        logic [1:0]             mode;
        logic [1:0]             st_q;
        logic [1:0]             st_d;
        logic [WC_W-1:0]        wc_q;
        logic [WC_W-1:0]        wc_d;
        logic [CNT_W-1:0]       pd_q;
        logic [CNT_W-1:0]       pd_d;
        logic                   pulse_q;
        logic                   pulse_d;
        logic                   ovf_q;
        // The chain and p keep running while disabled so re-enabling never
        // exposes a stale edge.
        always_ff @(posedge fast_clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                p_q    <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], async_in[i]};
                p_q    <= s;
            end
        end
        assign s    = sync_q[SYNC_STAGES-1];
        assign rise = s & ~p_q;
        assign fall = ~s & p_q;
        assign mode = edge_mode[2*i +: 2];
        assign evt  = ch_en[i] & (mode == 2'b01 ? fall : mode == 2'b10 ? (rise | fall) : rise);
        always_comb begin
            st_d    = st_q;
            wc_d    = wc_q;
            pd_d    = pd_q;
            pulse_d = pulse_q;
            drop    = 1'b0;
            if (!ch_en[i]) begin
                st_d    = IDLE;
                wc_d    = '0;
                pd_d    = '0;
                pulse_d = 1'b0;
            end else begin
                case (st_q)
                    IDLE: begin
                        if (evt) begin
                            st_d    = HIGH;
                            wc_d    = WC_INIT;
                            pulse_d = 1'b1;
                        end
                    end
                    HIGH: begin
                        if (wc_q == '0) begin
                            st_d    = GAP;
                            pulse_d = 1'b0;
                        end else begin
                            wc_d = wc_q - WC_W'(1);
                        end
                        if (evt) begin
                            if (pd_q != PEND_MAX) pd_d = pd_q + CNT_W'(1);
                            else drop = 1'b1;
                        end
                    end
                    GAP: begin
                        // An event in the gap with an empty queue is enqueued and
                        // dequeued at once; with a non-empty queue it cancels the dequeue.
                        if (pd_q != '0 || evt) begin
                            st_d    = HIGH;
                            wc_d    = WC_INIT;
                            pulse_d = 1'b1;
                            pd_d    = (pd_q != '0 && !evt) ? pd_q - CNT_W'(1) : pd_q;
                        end else begin
                            st_d = IDLE;
                        end
                    end
                    default: begin
                        st_d    = IDLE;
                        pulse_d = 1'b0;
                    end
                endcase
            end
        end
        always_ff @(posedge fast_clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q    <= IDLE;
                wc_q    <= '0;
                pd_q    <= '0;
                pulse_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                st_q    <= st_d;
                wc_q    <= wc_d;
                pd_q    <= pd_d;
                pulse_q <= pulse_d;
                // A drop in the same cycle as a clear keeps the flag set.
                ovf_q   <= drop | (ovf_q & ~ovf_clr[i]);
            end
        end
        assign fast_pulse[i] = pulse_q;
        assign busy[i]       = (st_q != IDLE) | (pd_q != '0);
        assign overflow[i]   = ovf_q;
    end
endmodule

// File: tb/tb_multi_ch_pulse_sync.sv
// tb_multi_ch_pulse_sync: randomized and directed checks against an event-queue reference model
module tb_multi_ch_pulse_sync;
    localparam int NUM_CH      = 2;
    localparam int SYNC_STAGES = 2;
    localparam int PULSE_W     = 3;
    localparam int CNT_W       = 2;
    localparam int PMAX        = (1 << CNT_W) - 1;

    logic                 fast_clk = 1'b0;
    logic                 rst_n    = 1'b0;
    logic [NUM_CH-1:0]    async_in = '0;
    logic [NUM_CH-1:0]    ch_en    = '0;
    logic [2*NUM_CH-1:0]  edge_mode = '0;
    logic [NUM_CH-1:0]    ovf_clr  = '0;
    logic [NUM_CH-1:0]    fast_pulse;
    logic [NUM_CH-1:0]    busy;
    logic [NUM_CH-1:0]    overflow;

    always #5 fast_clk = ~fast_clk;

    multi_ch_pulse_sync #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .PULSE_W(PULSE_W), .CNT_W(CNT_W)
    ) dut (
        .fast_clk(fast_clk), .rst_n(rst_n), .async_in(async_in), .ch_en(ch_en),
        .edge_mode(edge_mode), .ovf_clr(ovf_clr), .fast_pulse(fast_pulse),
        .busy(busy), .overflow(overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: history of sampled inputs, and per channel the age of
    // the current pulse (-1 idle, 0..PULSE_W-1 high, PULSE_W gap) plus queue depth.
    logic [NUM_CH-1:0] hist[$];
    int age  [NUM_CH];
    int pend [NUM_CH];
    bit ovf  [NUM_CH];
    int hold [NUM_CH];

    task automatic mdl_reset();
        hist.delete();
        for (int k = 0; k <= SYNC_STAGES; k++) hist.push_back('0);
        for (int c = 0; c < NUM_CH; c++) begin
            age[c]  = -1;
            pend[c] = 0;
            ovf[c]  = 1'b0;
        end
    endtask

    task automatic mdl_step();
        bit s, p, e, drop;
        logic [1:0] m;
        for (int c = 0; c < NUM_CH; c++) begin
            s    = hist[SYNC_STAGES-1][c];
            p    = hist[SYNC_STAGES][c];
            m    = edge_mode[2*c +: 2];
            e    = ch_en[c] && ((m == 2'b01) ? (!s && p) : (m == 2'b10) ? (s != p) : (s && !p));
            drop = 1'b0;
            if (!ch_en[c]) begin
                age[c]  = -1;
                pend[c] = 0;
            end else if (age[c] < 0) begin
                if (e) age[c] = 0;
            end else if (age[c] < PULSE_W) begin
                age[c]++;
                if (e) begin
                    if (pend[c] < PMAX) pend[c]++;
                    else drop = 1'b1;
                end
            end else if (pend[c] > 0) begin
                age[c] = 0;
                if (!e) pend[c]--;
            end else begin
                age[c] = e ? 0 : -1;
            end
            if (drop) ovf[c] = 1'b1;
            else if (ovf_clr[c]) ovf[c] = 1'b0;
        end
        hist.push_front(async_in);
        void'(hist.pop_back());
    endtask

    function automatic logic [NUM_CH-1:0] exp_pulse();
        logic [NUM_CH-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = (age[c] >= 0) && (age[c] < PULSE_W);
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_busy();
        logic [NUM_CH-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = (age[c] >= 0) || (pend[c] > 0);
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_ovf();
        logic [NUM_CH-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = ovf[c];
        return r;
    endfunction

    // Advance one clock with the current inputs and compare against the model.
    task automatic cycle();
        mdl_step();
        @(negedge fast_clk);
        check("fast_pulse", 32'(fast_pulse), 32'(exp_pulse()));
        check("busy", 32'(busy), 32'(exp_busy()));
        check("overflow", 32'(overflow), 32'(exp_ovf()));
    endtask

    // ch0 rises just before the next edge N: high after N+2..N+4, gap after N+5, idle after N+6.
    task automatic single_pulse(input string tag);
        logic [6:0] pp;
        logic [6:0] bp;
        pp = 7'b0011100;
        bp = 7'b0011110;
        async_in = 2'b01;
        for (int j = 0; j < 7; j++) begin
            cycle();
            check({tag, "_pulse0"}, 32'(fast_pulse[0]), 32'(pp[6-j]));
            check({tag, "_busy0"}, 32'(busy[0]), 32'(bp[6-j]));
            check({tag, "_pulse1"}, 32'(fast_pulse[1]), 32'(1'b0));
        end
    endtask

    initial begin
        mdl_reset();
        repeat (3) @(negedge fast_clk);
        check("rst_pulse", 32'(fast_pulse), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        rst_n = 1'b1;
        ch_en = '1;
        @(negedge fast_clk);
        mdl_step();
        single_pulse("rise");

        // Both-edge toggling every 3 cycles outpaces the 4-cycle pulse period.
        edge_mode[1:0] = 2'b10;
        for (int t = 0; t < 90; t++) begin
            if (t % 3 == 0) async_in[0] = ~async_in[0];
            cycle();
        end
        check("sat_ovf0", 32'(overflow[0]), 32'(1'b1));
        ovf_clr[0] = 1'b1;
        cycle();
        ovf_clr[0] = 1'b0;
        check("clr_ovf0", 32'(overflow[0]), 32'(1'b0));
        repeat (30) cycle();
        check("drain_busy0", 32'(busy[0]), 32'(1'b0));

        for (int c = 0; c < NUM_CH; c++) hold[c] = 3;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (--hold[c] == 0) begin
                    async_in[c] = ~async_in[c];
                    hold[c] = ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(3, 9));
                end
                ovf_clr[c] = ($urandom_range(0, 9) == 0);
                if (ch_en[c]) begin
                    if ($urandom_range(0, 99) == 0) begin
                        ch_en[c] = 1'b0;
                        edge_mode[2*c +: 2] = 2'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    ch_en[c] = 1'b1;
                end
            end
            cycle();
        end

        // Reset in the middle of activity, then release with ch0 already high.
        ch_en = '1;
        edge_mode = '0;
        ovf_clr = '0;
        async_in = 2'b00;
        repeat (6) cycle();
        async_in = 2'b01;
        repeat (4) cycle();
        async_in = 2'b00;
        repeat (3) cycle();
        async_in = 2'b01;
        repeat (4) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_pulse", 32'(fast_pulse), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_ovf", 32'(overflow), 32'(0));
        @(negedge fast_clk);
        mdl_reset();
        rst_n = 1'b1;
        single_pulse("post_rst");
        repeat (10) cycle();
        check("post_rst_idle", 32'(busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
